mem_arbiter: RTL and testbench

Two-port arbiter that shares one single-port, fixed-latency unified memory between the pipeline's instruction-fetch port (IF) and data-memory port (DM, the MEM stage). It serialises accesses, drives the memory, returns read data with a one-cycle acknowledge pulse, and raises a pipeline stall while any request is outstanding. It sits between the CPU core and the memory macro, and replaces the separate instruction and data memories.

---
 rtl/mem_arb_pkg.sv | 13 +
 rtl/mem_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_arbiter.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for mem_arbiter: FSM state encoding and requester ids.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } arb_state_e;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_DM = 1'b1;

endpackage

// File: rtl/mem_arbiter.sv
// Shares one fixed-latency single-port memory between the IF and DM ports.
// Define ARB_RR_EN for round-robin tie breaking; default is fixed DM priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int LAT = 2,
    parameter int AW  = 32,
    parameter int DW  = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ack,
    output logic [DW-1:0] if_rdata,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_ack,
    output logic [DW-1:0] dm_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          stall,
    output logic          busy
);

    localparam int            CW       = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(LAT - 1);

    arb_state_e    state_q;
    logic [CW-1:0] cnt_q;
    logic          gnt_q;
    logic          if_ack_q, dm_ack_q;
    logic          mem_en_q, mem_we_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q, if_rdata_q, dm_rdata_q;

    logic if_cand, dm_cand, gnt_d;

`ifdef ARB_RR_EN
    logic last_q;

    function automatic logic pick_port(input logic if_c, input logic dm_c, input logic last);
        return (if_c && dm_c) ? ~last : (dm_c || !if_c);
    endfunction
`else
    function automatic logic pick_port(input logic if_c, input logic dm_c);
        return dm_c || !if_c;
    endfunction
`endif

    // A port whose ack is showing this cycle has finished and may not be re-granted yet.
    assign if_cand = if_req && !if_ack_q;
    assign dm_cand = dm_req && !dm_ack_q;

`ifdef ARB_RR_EN
    assign gnt_d = pick_port(if_cand, dm_cand, last_q);
`else
    assign gnt_d = pick_port(if_cand, dm_cand);
`endif

    // NOTE: all state below updates with non-blocking assignments so every
    // register samples the pre-edge values, whatever order the statements are in.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            gnt_q       <= PORT_IF;
            if_ack_q    <= 1'b0;
            dm_ack_q    <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
`ifdef ARB_RR_EN
            last_q      <= PORT_IF;
`endif
        end else begin
            if_ack_q <= 1'b0;
            dm_ack_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_RESP: begin
                    if (if_cand || dm_cand) begin
                        state_q    <= ST_ACCESS;
                        cnt_q      <= CNT_LOAD;
                        gnt_q      <= gnt_d;
                        mem_en_q   <= 1'b1;
                        mem_we_q   <= (gnt_d == PORT_DM) && dm_we;
                        mem_addr_q <= (gnt_d == PORT_DM) ? dm_addr : if_addr;
                        if (gnt_d == PORT_DM) begin
                            mem_wdata_q <= dm_wdata;
                        end
`ifdef ARB_RR_EN
                        // Only contested grants move the round-robin pointer.
                        if (if_cand && dm_cand) begin
                            last_q <= gnt_d;
                        end
`endif
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    if (cnt_q == '0) begin
                        state_q  <= ST_RESP;
                        mem_en_q <= 1'b0;
                        mem_we_q <= 1'b0;
                        // A withdrawn request still gets its data stored, but no ack.
                        if (gnt_q == PORT_IF) begin
                            if_rdata_q <= mem_rdata;
                            if_ack_q   <= if_req;
                        end else begin
                            if (!mem_we_q) begin
                                dm_rdata_q <= mem_rdata;
                            end
                            dm_ack_q <= dm_req;
                        end
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign if_ack    = if_ack_q;
    assign dm_ack    = dm_ack_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = mem_en_q;
    assign stall     = (if_req && !if_ack_q) || (dm_req && !dm_ack_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural LAT-cycle memory and an ack scoreboard.
// Build with ARB_RR_EN defined to exercise the round-robin tie expectations.
module tb_mem_arbiter;

    localparam int LAT = 2;
    localparam int AW  = 32;
    localparam int DW  = 32;

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req, dm_req, dm_we;
    logic [AW-1:0] if_addr, dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          if_ack, dm_ack, mem_en, mem_we, stall, busy;
    logic [DW-1:0] if_rdata, dm_rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;

    exp_t if_sb[$];
    exp_t dm_sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   dm_hold_acks = 0;
    logic if_seen = 1'b0;
    logic dm_seen = 1'b0;

    always #5 clk = ~clk;

    mem_arbiter #(.LAT(LAT), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ack    (if_ack),
        .if_rdata  (if_rdata),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_ack    (dm_ack),
        .dm_rdata  (dm_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .stall     (stall),
        .busy      (busy)
    );

    // Memory model: data only valid in the LAT-th consecutive mem_en cycle, X otherwise.
    logic [DW-1:0] mem_arr [0:255];
    int            run_q;

    always @(posedge clk) begin
        if (!rst) mem_arr[16] <= 32'h1234_5678;
        else if (mem_en && mem_we) mem_arr[mem_addr[9:2]] <= mem_wdata;
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) run_q <= 0;
        else      run_q <= mem_en ? run_q + 1 : 0;
    end

    assign mem_rdata = (mem_en && run_q == LAT - 1) ? mem_arr[mem_addr[9:2]] : {DW{1'bx}};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_if(input logic [DW-1:0] data, input int ack_cyc);
        exp_t e;
        e.data = data;
        e.cyc  = ack_cyc;
        if_sb.push_back(e);
    endtask

    task automatic push_dm(input logic [DW-1:0] data, input int ack_cyc);
        exp_t e;
        e.data = data;
        e.cyc  = ack_cyc;
        dm_sb.push_back(e);
    endtask

    // Mid-cycle sample: pop the scoreboard on acks, flag acks that are missing or unexpected.
    task automatic sample();
        exp_t e;
        @(negedge clk);
        if_seen = if_ack;
        dm_seen = dm_ack;
        if (if_ack) begin
            if (if_sb.size() == 0) check("if_ack_spurious", if_ack, 1'b0);
            else begin
                e = if_sb.pop_front();
                check("if_rdata", if_rdata, e.data);
                check("if_ack_cycle", cyc, e.cyc);
            end
        end else if (if_sb.size() != 0 && if_sb[0].cyc == cyc) begin
            check("if_ack_missing", if_ack, 1'b1);
            void'(if_sb.pop_front());
        end
        if (dm_ack) begin
            if (dm_sb.size() == 0) check("dm_ack_spurious", dm_ack, 1'b0);
            else begin
                e = dm_sb.pop_front();
                check("dm_rdata", dm_rdata, e.data);
                check("dm_ack_cycle", cyc, e.cyc);
            end
        end else if (dm_sb.size() != 0 && dm_sb[0].cyc == cyc) begin
            check("dm_ack_missing", dm_ack, 1'b1);
            void'(dm_sb.pop_front());
        end
    endtask

    // Step to just after the next rising edge; requesters drop req after their ack.
    task automatic advance();
        @(posedge clk);
        #1;
        cyc++;
        if (if_seen) if_req = 1'b0;
        if (dm_seen) begin
            if (dm_hold_acks > 0) dm_hold_acks--;
            else begin
                dm_req = 1'b0;
                dm_we  = 1'b0;
            end
        end
        if_seen = 1'b0;
        dm_seen = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            sample();
            advance();
        end
    endtask

    task automatic sb_done(input string tag);
        check({tag, "_if_outstanding"}, if_sb.size(), 0);
        check({tag, "_dm_outstanding"}, dm_sb.size(), 0);
        if_sb.delete();
        dm_sb.delete();
    endtask

    task automatic do_reset();
        rst    = 1'b0;
        if_req = 1'b0;
        dm_req = 1'b0;
        dm_we  = 1'b0;
        advance();
        advance();
        rst = 1'b1;
        if_sb.delete();
        dm_sb.delete();
        advance();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time observed %0t, required completion before it", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
        if_addr = '0; dm_addr = '0; dm_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_mem_en", mem_en, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_acks", {if_ack, dm_ack}, 2'b00);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_rdata", {if_rdata, dm_rdata}, 64'h0);
        check("rst_stall", stall, 1'b0);
        rst = 1'b1;
        advance();

        // IF-only read of 0x40
        cyc = 0; if_addr = 32'h40; if_req = 1'b1;
        push_if(32'h1234_5678, 3);
        sample(); check("t1_c0_mem_en", mem_en, 1'b0); check("t1_c0_stall", stall, 1'b1); advance();
        sample(); check("t1_c1_mem_en", mem_en, 1'b1); check("t1_c1_mem_addr", mem_addr, 32'h40);
                  check("t1_c1_mem_we", mem_we, 1'b0); check("t1_c1_busy", busy, 1'b1); advance();
        sample(); check("t1_c2_mem_en", mem_en, 1'b1); advance();
        sample(); check("t1_c3_stall", stall, 1'b0); check("t1_c3_mem_en", mem_en, 1'b0); advance();
        sample(); check("t1_c4_if_ack", if_ack, 1'b0); check("t1_c4_if_rdata", if_rdata, 32'h1234_5678);
                  check("t1_c4_busy", busy, 1'b0); check("t1_c4_stall", stall, 1'b0); advance();
        sb_done("t1");

        // DM write to 0x80, then IF read of the same address; dm_rdata stays at its reset value
        cyc = 0; dm_addr = 32'h80; dm_wdata = 32'hDEAD_BEEF; dm_we = 1'b1; dm_req = 1'b1;
        push_dm(32'h0, 3);
        sample(); advance();
        sample(); check("t2_c1_mem_we", mem_we, 1'b1); check("t2_c1_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
                  check("t2_c1_mem_addr", mem_addr, 32'h80); advance();
        run(3);
        cyc = 0; if_addr = 32'h80; if_req = 1'b1;
        push_if(32'hDEAD_BEEF, 3);
        run(5);
        sb_done("t2");

        // Two ties in a row: IF reads 0x40, DM reads 0x80
        do_reset();
        cyc = 0; if_addr = 32'h40; dm_addr = 32'h80; dm_we = 1'b0; if_req = 1'b1; dm_req = 1'b1;
        push_dm(32'hDEAD_BEEF, 3);
        push_if(32'h1234_5678, 6);
        run(3);
        sample(); check("t3_c3_stall", stall, 1'b1); advance();
        sample(); check("t3_c4_no_bubble", mem_en, 1'b1); advance();
        run(2);
        cyc = 0; if_req = 1'b1; dm_req = 1'b1;
`ifdef ARB_RR_EN
        push_if(32'h1234_5678, 3);
        push_dm(32'hDEAD_BEEF, 6);
`else
        push_dm(32'hDEAD_BEEF, 3);
        push_if(32'h1234_5678, 6);
`endif
        run(8);
        sb_done("t3");

        // DM keeps requesting while IF waits; IF must still be served
        do_reset();
        cyc = 0; dm_hold_acks = 1; if_addr = 32'h80; dm_addr = 32'h40; dm_we = 1'b0;
        if_req = 1'b1; dm_req = 1'b1;
        push_dm(32'h1234_5678, 3);
        push_if(32'hDEAD_BEEF, 6);
        push_dm(32'h1234_5678, 9);
        run(11);
        sb_done("t4");

        // IF request withdrawn during ACCESS: no ack, data still captured, back to IDLE
        cyc = 0; if_addr = 32'h40; if_req = 1'b1;
        sample(); advance();
        if_req = 1'b0;
        sample(); check("t5_c1_stall", stall, 1'b0); advance();
        sample(); check("t5_c2_mem_en", mem_en, 1'b1); advance();
        sample(); check("t5_c3_if_ack", if_ack, 1'b0); advance();
        sample(); check("t5_c4_busy", busy, 1'b0); check("t5_c4_if_rdata", if_rdata, 32'h1234_5678); advance();
        sb_done("t5");

        // Reset during cycle 1 of a DM write, then a normal IF read
        cyc = 0; dm_addr = 32'h44; dm_wdata = 32'h55AA_33CC; dm_we = 1'b1; dm_req = 1'b1;
        sample(); advance();
        check("t6_c1_mem_addr", mem_addr, 32'h44);
        rst = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
        #1;
        check("t6_rst_mem_strobes", {mem_en, mem_we, busy}, 3'b000);
        check("t6_rst_acks", {if_ack, dm_ack, stall}, 3'b000);
        check("t6_rst_mem_bus", {mem_addr, mem_wdata}, 64'h0);
        check("t6_rst_rdata", {if_rdata, dm_rdata}, 64'h0);
        sample(); advance();
        sample(); advance();
        rst = 1'b1;
        cyc = 0; if_addr = 32'h40; if_req = 1'b1;
        push_if(32'h1234_5678, 3);
        run(5);
        sb_done("t6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
